// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Dual-load-port data memory fronted by a committed-store FIFO.
//                Loads are combinational and see buffered stores through
//                byte-accurate forwarding; the buffer drains one entry per
//                cycle into the word array.
//  Revision    : 1.0  initial release
// ============================================================================

package data_memory_pkg;
  typedef logic [2:0] ldst_mode_t;

  localparam ldst_mode_t MODE_B  = 3'b000;
  localparam ldst_mode_t MODE_H  = 3'b001;
  localparam ldst_mode_t MODE_W  = 3'b010;
  localparam ldst_mode_t MODE_BU = 3'b100;
  localparam ldst_mode_t MODE_HU = 3'b101;
endpackage

module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int SB_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  ldst_mode_t  load_mode [2],
  input  logic [31:0] load_addr [2],
  output logic [31:0] load_data [2],
  input  logic        store_valid,
  output logic        store_ready,
  input  ldst_mode_t  store_mode,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        sb_empty
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);

  // Overlay the bytes selected by mask onto a base word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  // Word array (never reset) and store-buffer state.
  logic [31:0]      mem_q     [MEM_WORDS];
  logic [IDX_W-1:0] sb_idx_q  [SB_DEPTH];
  logic [IDX_W-1:0] sb_idx_d  [SB_DEPTH];
  logic [3:0]       sb_mask_q [SB_DEPTH];
  logic [3:0]       sb_mask_d [SB_DEPTH];
  logic [31:0]      sb_data_q [SB_DEPTH];
  logic [31:0]      sb_data_d [SB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq;
  logic             drain_en;
  logic [IDX_W-1:0] st_idx;
  logic [3:0]       st_mask;
  logic [31:0]      st_data;
  logic [IDX_W-1:0] drain_idx;
  logic [3:0]       drain_mask;
  logic [31:0]      drain_data;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{store_addr[31:IDX_W+2],
                              load_addr[0][31:IDX_W+2],
                              load_addr[1][31:IDX_W+2]};

  // Full/empty come from the occupancy count, never from pointer equality.
  assign drain_en    = (count_q != '0);
  assign sb_empty    = (count_q == '0);
  assign store_ready = (count_q < SB_FULL) && !reset;
  assign enq         = store_valid && store_ready;

  assign drain_idx  = sb_idx_q[head_q];
  assign drain_mask = sb_mask_q[head_q];
  assign drain_data = sb_data_q[head_q];

  // Turn the committed store into a word index, byte mask and lane-replicated data.
  always_comb begin
    st_idx  = store_addr[IDX_W+1:2];
    st_mask = 4'b0000;
    st_data = store_data;
    case (store_mode)
      MODE_B: begin
        st_mask = 4'b0001 << store_addr[1:0];
        st_data = {4{store_data[7:0]}};
      end
      MODE_H: begin
        st_mask = store_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data[15:0]}};
      end
      MODE_W:  st_mask = 4'b1111;
      default: st_mask = 4'b0000;
    endcase
  end

  // Next-state for the FIFO: enqueue at tail, retire head, track occupancy.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    sb_idx_d  = sb_idx_q;
    sb_mask_d = sb_mask_q;
    sb_data_d = sb_data_q;
    if (enq) begin
      sb_idx_d[tail_q]  = st_idx;
      sb_mask_d[tail_q] = st_mask;
      sb_data_d[tail_q] = st_data;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (drain_en) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({enq, drain_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards every buffered store.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset: only slots inside the count are ever used.
  always_ff @(posedge clk) begin
    sb_idx_q  <= sb_idx_d;
    sb_mask_q <= sb_mask_d;
    sb_data_q <= sb_data_d;
  end

  // Drain the head entry into the array; suppressed under reset.
  always_ff @(posedge clk) begin
    if (drain_en && !reset) begin
      mem_q[drain_idx] <= merge_bytes(mem_q[drain_idx], drain_data, drain_mask);
    end
  end

  // Per-lane load: array word, overlay buffered entries oldest-first, extract and extend.
  always_comb begin
    logic [IDX_W-1:0] lane_idx;
    logic [31:0]      lane_word;
    logic [PTR_W-1:0] slot;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    lane_idx  = '0;
    lane_word = '0;
    slot      = '0;
    lane_byte = '0;
    lane_half = '0;
    for (int l = 0; l < 2; l++) begin
      lane_idx  = load_addr[l][IDX_W+1:2];
      lane_word = mem_q[lane_idx];
      for (int k = 0; k < SB_DEPTH; k++) begin
        slot = head_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && (sb_idx_q[slot] == lane_idx)) begin
          lane_word = merge_bytes(lane_word, sb_data_q[slot], sb_mask_q[slot]);
        end
      end
      lane_byte = lane_word[{load_addr[l][1:0], 3'b000} +: 8];
      lane_half = load_addr[l][1] ? lane_word[31:16] : lane_word[15:0];
      case (load_mode[l])
        MODE_B:  load_data[l] = {{24{lane_byte[7]}}, lane_byte};
        MODE_H:  load_data[l] = {{16{lane_half[15]}}, lane_half};
        MODE_W:  load_data[l] = lane_word;
        MODE_BU: load_data[l] = {24'd0, lane_byte};
        MODE_HU: load_data[l] = {16'd0, lane_half};
        default: load_data[l] = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory; load expectations are
//                queued as stimulus is driven and compared when sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  ldst_mode_t  load_mode [2];
  logic [31:0] load_addr [2];
  logic [31:0] load_data [2];
  logic        store_valid = 1'b0;
  logic        store_ready;
  ldst_mode_t  store_mode = MODE_W;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic        sb_empty;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    int          lane;
    logic [31:0] expv;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] exp_w [10];

  data_memory #(.MEM_WORDS(4096), .SB_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_mode  (load_mode),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .store_valid(store_valid),
    .store_ready(store_ready),
    .store_mode (store_mode),
    .store_addr (store_addr),
    .store_data (store_data),
    .sb_empty   (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input string tag, input int lane, input ldst_mode_t mode,
                             input logic [31:0] addr, input logic [31:0] expv);
    exp_t e;
    load_mode[lane] = mode;
    load_addr[lane] = addr;
    e.tag  = tag;
    e.lane = lane;
    e.expv = expv;
    exp_q.push_back(e);
  endtask

  task automatic compare_loads();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, load_data[e.lane], e.expv);
    end
  endtask

  task automatic put_store(input ldst_mode_t m, input logic [31:0] a, input logic [31:0] d);
    store_valid = 1'b1;
    store_mode  = m;
    store_addr  = a;
    store_data  = d;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!sb_empty && n < 20) begin
      step();
      n++;
    end
    check_eq(tag, 32'(sb_empty), 32'd1);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    put_store(MODE_W, a, d);
    step();
    store_valid = 1'b0;
    wait_empty("preload_empty");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    load_mode[0] = MODE_W;
    load_mode[1] = MODE_W;
    load_addr[0] = '0;
    load_addr[1] = '0;

    // Reset state
    step();
    step();
    #1;
    check_eq("reset_ready", 32'(store_ready), 32'd0);
    check_eq("reset_empty", 32'(sb_empty), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", 32'(store_ready), 32'd1);
    step();

    // Sub-word loads
    preload(32'h10, 32'h8081_7F01);
    expect_load("lb_10", 0, MODE_B, 32'h10, 32'h0000_0001);
    expect_load("lb_13", 1, MODE_B, 32'h13, 32'hFFFF_FF80);
    compare_loads();
    expect_load("lbu_13", 0, MODE_BU, 32'h13, 32'h0000_0080);
    expect_load("lh_12", 1, MODE_H, 32'h12, 32'hFFFF_8081);
    compare_loads();
    expect_load("lhu_13", 0, MODE_HU, 32'h13, 32'h0000_8081);
    expect_load("lw_11", 1, MODE_W, 32'h11, 32'h8081_7F01);
    compare_loads();
    expect_load("lb_11", 0, MODE_B, 32'h11, 32'h0000_007F);
    expect_load("bad_mode", 1, 3'b011, 32'h10, 32'h0000_0000);
    compare_loads();
    expect_load("lh_10", 0, MODE_H, 32'h10, 32'h0000_7F01);
    compare_loads();

    // Forwarding before drain
    preload(32'h20, 32'h0);
    put_store(MODE_B, 32'h21, 32'h1234_56AB);
    step();
    store_valid = 1'b0;
    check_eq("fwd_pending", 32'(sb_empty), 32'd0);
    expect_load("fwd_l0", 0, MODE_W, 32'h20, 32'h0000_AB00);
    expect_load("fwd_l1", 1, MODE_W, 32'h20, 32'h0000_AB00);
    compare_loads();
    step();
    check_eq("fwd_drained", 32'(sb_empty), 32'd1);
    expect_load("fwd_arr_l0", 0, MODE_W, 32'h20, 32'h0000_AB00);
    expect_load("fwd_arr_l1", 1, MODE_W, 32'h20, 32'h0000_AB00);
    compare_loads();

    // Youngest wins
    put_store(MODE_W, 32'h40, 32'h1111_1111);
    step();
    put_store(MODE_H, 32'h42, 32'h9999_2222);
    expect_load("yw_1", 0, MODE_W, 32'h40, 32'h1111_1111);
    compare_loads();
    check_eq("yw_ready", 32'(store_ready), 32'd1);
    step();
    put_store(MODE_B, 32'h40, 32'h7777_7733);
    expect_load("yw_2", 0, MODE_W, 32'h40, 32'h2222_1111);
    compare_loads();
    step();
    store_valid = 1'b0;
    expect_load("yw_3", 0, MODE_W, 32'h40, 32'h2222_1133);
    compare_loads();
    wait_empty("yw_empty");
    expect_load("yw_arr", 1, MODE_W, 32'h40, 32'h2222_1133);
    compare_loads();

    // Back-to-back stores never fill the buffer
    for (int i = 0; i < 6; i++) begin
      put_store(MODE_W, 32'h60 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      #1;
      check_eq("hold_ready", 32'(store_ready), 32'd1);
      step();
    end
    store_valid = 1'b0;
    wait_empty("hold_empty");
    expect_load("hold_w0", 0, MODE_W, 32'h60, 32'hC0DE_0000);
    expect_load("hold_w5", 1, MODE_W, 32'h74, 32'hC0DE_0005);
    compare_loads();

    // Full buffer / backpressure with drain held off
    preload(32'h110, 32'h5A5A_5A5A);
    force dut.drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_store(MODE_W, 32'h100 + 32'(4 * i), 32'hF000_0000 + 32'(i));
      #1;
      check_eq("fill_ready", 32'(store_ready), 32'd1);
      step();
    end
    put_store(MODE_W, 32'h110, 32'hBAD0_BAD0);
    #1;
    check_eq("full_ready", 32'(store_ready), 32'd0);
    expect_load("full_fwd0", 0, MODE_W, 32'h100, 32'hF000_0000);
    expect_load("full_fwd3", 1, MODE_W, 32'h10C, 32'hF000_0003);
    compare_loads();
    step();
    check_eq("full_held", 32'(store_ready), 32'd0);
    step();
    store_valid = 1'b0;
    expect_load("full_reject", 0, MODE_W, 32'h110, 32'h5A5A_5A5A);
    compare_loads();
    release dut.drain_en;
    #1;
    check_eq("full_before_drain", 32'(store_ready), 32'd0);
    step();
    check_eq("ready_after_drain", 32'(store_ready), 32'd1);
    wait_empty("full_empty");
    expect_load("full_arr1", 0, MODE_W, 32'h104, 32'hF000_0001);
    expect_load("full_arr_x", 1, MODE_W, 32'h110, 32'h5A5A_5A5A);
    compare_loads();

    // Reset mid-operation
    preload(32'h50, 32'h0);
    preload(32'h54, 32'hAAAA_0054);
    preload(32'h58, 32'hAAAA_0058);
    put_store(MODE_W, 32'h50, 32'h0000_0011);
    step();
    put_store(MODE_W, 32'h54, 32'h0000_0022);
    step();
    put_store(MODE_W, 32'h58, 32'h0000_0033);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_ready", 32'(store_ready), 32'd0);
    step();
    reset = 1'b0;
    store_valid = 1'b0;
    #1;
    check_eq("rst_mid_empty", 32'(sb_empty), 32'd1);
    step();
    step();
    expect_load("rst_50", 0, MODE_W, 32'h50, 32'h0000_0011);
    expect_load("rst_54", 1, MODE_W, 32'h54, 32'hAAAA_0054);
    compare_loads();
    expect_load("rst_58", 0, MODE_W, 32'h58, 32'hAAAA_0058);
    compare_loads();

    // Address aliasing
    put_store(MODE_W, 32'h0000_4004, 32'hDEAD_BEEF);
    step();
    store_valid = 1'b0;
    expect_load("alias_fwd", 0, MODE_W, 32'h0000_0004, 32'hDEAD_BEEF);
    expect_load("alias_fwd_hi", 1, MODE_W, 32'h0000_8006, 32'hDEAD_BEEF);
    compare_loads();
    wait_empty("alias_empty");
    expect_load("alias_arr", 0, MODE_W, 32'h0000_0004, 32'hDEAD_BEEF);
    compare_loads();

    // Pointer wrap over many enqueue/drain cycles
    for (int i = 0; i < 10; i++) begin
      exp_w[i] = $urandom;
      put_store(MODE_W, 32'h200 + 32'(4 * i), exp_w[i]);
      step();
      expect_load("wrap_fwd", 1, MODE_W, 32'h200 + 32'(4 * i), exp_w[i]);
      if (i > 0) expect_load("wrap_prev", 0, MODE_W, 32'h200 + 32'(4 * (i - 1)), exp_w[i - 1]);
      compare_loads();
    end
    store_valid = 1'b0;
    wait_empty("wrap_empty");
    for (int i = 0; i < 10; i++) begin
      expect_load("wrap_arr", 0, MODE_W, 32'h200 + 32'(4 * i), exp_w[i]);
      compare_loads();
    end

    // Halfword store ignores addr[0]; unused store mode writes nothing
    put_store(MODE_H, 32'h203, 32'h0000_CAFE);
    step();
    put_store(3'b011, 32'h204, 32'hFFFF_FFFF);
    step();
    store_valid = 1'b0;
    wait_empty("misc_empty");
    expect_load("sh_odd", 0, MODE_W, 32'h200, {16'hCAFE, exp_w[0][15:0]});
    expect_load("mode_nop", 1, MODE_W, 32'h204, exp_w[1]);
    compare_loads();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
